ex_wb_hazard_ctrl: RTL
======================

// Module: ex_wb_hazard_ctrl
// PURPOSE
//  Receiving end of the ID/EX control bundle. Carries the EX-stage control word
//  (reg_write, mem_read, mem_write, mem_to_reg) plus the resolved destination
//  register through the EX/MEM and MEM/WB control registers.
//  Generates the forwarding selects for EX operands from these registers.
//  Detects load-use hazards and drives the stall and bubble controls back
//  toward IF/ID and ID/EX.
// PARAMETERS
//  RW        5   register-address width
//  LU_BUBBLES 1  bubbles inserted per load-use hazard (1..3)
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   synchronous, active-high reset
//  ex_reg_write   in   1   ID/EX control: reg_write
//  ex_mem_read    in   1   ID/EX control: mem_read
//  ex_mem_write   in   1   ID/EX control: mem_write
//  ex_mem_to_reg  in   2   ID/EX control: mem_to_reg
//  ex_rd          in   RW  EX destination register, after the reg_dst mux
//  ex_rs,ex_rt    in   RW  EX source registers
//  id_rs,id_rt    in   RW  ID source registers
//  id_uses_rt     in   1   ID instruction reads rt
//  mem_wait       in   1   data memory busy; freezes the whole pipeline
//  mem_reg_write,mem_mem_read,mem_mem_write  out 1  EX/MEM control
//  mem_mem_to_reg out  2   EX/MEM control
//  mem_rd         out  RW  EX/MEM destination register
//  wb_reg_write   out  1   MEM/WB control
//  wb_mem_to_reg  out  2   MEM/WB control
//  wb_rd          out  RW  MEM/WB destination register
//  forward_a,forward_b out 2  00=register file, 10=EX/MEM, 01=MEM/WB
//  pc_write       out  1   PC update enable
//  if_id_write    out  1   IF/ID register enable
//  id_ex_write    out  1   ID/EX register enable
//  id_ex_flush    out  1   load a zero control word (bubble) into ID/EX
// BEHAVIOUR
//  - Reset: all EX/MEM and MEM/WB registers go to 0; FSM enters RUN; bubble counter = 0.
//  - While rst=1: forward_a/b=00, pc_write=if_id_write=id_ex_write=1, id_ex_flush=0.
//  - Pipeline registers:
//    - Update on posedge when rst=0 and mem_wait=0.
//    - EX/MEM <= ex_* inputs. MEM/WB <= EX/MEM values.
//    - Latency is 1 clock per stage.
//  - Freeze: mem_wait=1 holds all registers, the FSM and the counter.
//    - Outputs during freeze: pc_write=if_id_write=id_ex_write=0, id_ex_flush=0.
//    - Freeze has priority over stall.
//  - forward_a (combinational):
//    - 10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs;
//    - else 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs;
//    - else 00.
//    - EX/MEM has priority over MEM/WB.
//  - forward_b: same rules as forward_a, using ex_rt.
//  - Register 0 never forwards.
//  - hazard = ex_mem_read && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
//  - FSM RUN:
//    - If hazard: stall=1 this cycle (Mealy).
//    - If LU_BUBBLES>1: go to STALL, cnt=LU_BUBBLES-1.
//  - FSM STALL: stall=1; cnt decrements each unfrozen cycle; return to RUN when cnt reaches 1.
//  - Hazard detection is ignored in STALL.
//  - stall=1 => pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_write=1.
//  - When not stalled and not frozen: pc_write=if_id_write=id_ex_write=1, id_ex_flush=0.
//  - Reset asserted mid-STALL aborts the stall: RUN next cycle, all registers cleared.
// TESTING
//  - Reset: rst=1 for 2 clks with ex_reg_write=1 -> mem_*/wb_* all 0, forward_a=forward_b=00.
//  - EX/MEM forward:
//    - ex_reg_write=1, ex_rd=5, then next instr ex_rs=5 -> forward_a=10.
//    - One clk later with ex_rs=5 -> forward_a=01 (from MEM/WB).
//  - Priority and register 0:
//    - mem_rd=wb_rd=7, both writing, ex_rt=7 -> forward_b=10.
//    - ex_rd=0 chain -> forward stays 00.
//  - Load-use:
//    - ex_mem_read=1, ex_rd=3, id_rs=3 -> exactly 1 cycle of pc_write=0, id_ex_flush=1.
//    - Next cycle, with the load in MEM, dependent instr sees forward_a=01 after one more clk.
//    - id_rt=3 with id_uses_rt=0 -> no stall.
//  - mem_wait=1 for 3 clks during a load-use hazard:
//    - Registers hold, id_ex_flush=0, enables=0.
//    - Stall resumes after mem_wait falls.
//  - LU_BUBBLES=2, rst pulsed in the 2nd stall cycle -> next cycle RUN, pc_write=1, all registers 0.

Source files
------------

// File: rtl/ex_wb_hazard_ctrl.sv
// EX/MEM and MEM/WB control-register chain with operand forwarding selects and
// load-use hazard stall/bubble generation; mem_wait freezes the whole pipeline.
module ex_wb_hazard_ctrl #(
    parameter int RW         = 5,
    parameter int LU_BUBBLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_reg_write,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic [1:0]    ex_mem_to_reg,
    input  logic [RW-1:0] ex_rd,
    input  logic [RW-1:0] ex_rs,
    input  logic [RW-1:0] ex_rt,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rt,
    input  logic          mem_wait,
    output logic          mem_reg_write,
    output logic          mem_mem_read,
    output logic          mem_mem_write,
    output logic [1:0]    mem_mem_to_reg,
    output logic [RW-1:0] mem_rd,
    output logic          wb_reg_write,
    output logic [1:0]    wb_mem_to_reg,
    output logic [RW-1:0] wb_rd,
    output logic [1:0]    forward_a,
    output logic [1:0]    forward_b,
    output logic          pc_write,
    output logic          if_id_write,
    output logic          id_ex_write,
    output logic          id_ex_flush
);

    localparam int CNT_W = 2;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    // EX/MEM and MEM/WB control registers
    logic          mem_reg_write_q, mem_mem_read_q, mem_mem_write_q;
    logic [1:0]    mem_mem_to_reg_q;
    logic [RW-1:0] mem_rd_q;
    logic          wb_reg_write_q;
    logic [1:0]    wb_mem_to_reg_q;
    logic [RW-1:0] wb_rd_q;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;
    logic              stall;

    // EX/MEM wins over MEM/WB; register 0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic          src_reg,
        input logic          m_we,
        input logic [RW-1:0] m_rd,
        input logic          w_we,
        input logic [RW-1:0] w_rd,
        input logic [RW-1:0] src
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src_reg && m_we && (m_rd != '0) && (m_rd == src)) begin
            sel = 2'b10;
        end else if (src_reg && w_we && (w_rd != '0) && (w_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_reg_write_q  <= 1'b0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 2'b00;
            mem_rd_q         <= '0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 2'b00;
            wb_rd_q          <= '0;
        end else if (!mem_wait) begin
            mem_reg_write_q  <= ex_reg_write;
            mem_mem_read_q   <= ex_mem_read;
            mem_mem_write_q  <= ex_mem_write;
            mem_mem_to_reg_q <= ex_mem_to_reg;
            mem_rd_q         <= ex_rd;
            wb_reg_write_q   <= mem_reg_write_q;
            wb_mem_to_reg_q  <= mem_mem_to_reg_q;
            wb_rd_q          <= mem_rd_q;
        end
    end

    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    // The first bubble is issued from RUN; STALL covers the remaining LU_BUBBLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (hazard) begin
                    stall = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        state_d = S_STALL;
                        cnt_d   = CNT_W'(LU_BUBBLES - 1);
                    end
                end
            end
            S_STALL: begin
                stall = 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else if (!mem_wait) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset overrides freeze, freeze overrides stall.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_write = 1'b1;
        id_ex_flush = 1'b0;
        forward_a   = 2'b00;
        forward_b   = 2'b00;
        if (!rst) begin
            forward_a = fwd_sel(1'b1, mem_reg_write_q, mem_rd_q,
                                wb_reg_write_q, wb_rd_q, ex_rs);
            forward_b = fwd_sel(1'b1, mem_reg_write_q, mem_rd_q,
                                wb_reg_write_q, wb_rd_q, ex_rt);
            if (mem_wait) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_write = 1'b0;
            end else if (stall) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign mem_reg_write  = mem_reg_write_q;
    assign mem_mem_read   = mem_mem_read_q;
    assign mem_mem_write  = mem_mem_write_q;
    assign mem_mem_to_reg = mem_mem_to_reg_q;
    assign mem_rd         = mem_rd_q;
    assign wb_reg_write   = wb_reg_write_q;
    assign wb_mem_to_reg  = wb_mem_to_reg_q;
    assign wb_rd          = wb_rd_q;

endmodule
